// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage: owns the PC, drives the I-cache read handshake and
//   holds the IF/ID pipeline register. Cache wait states, redirects that arrive
//   while an access is stalled, and decode stalls that coincide with a fetch
//   completing are absorbed here (the latter through a one-entry skid buffer).
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   stall_pc          hold IF/ID and freeze PC advance
//   flush_if_id       squash IF/ID (and the skid buffer)
//   redirect_valid    taken branch/jump this cycle, target on redirect_pc
//   icache_stall      cache busy; icache_rdata valid when ren=1 and stall=0
//   icache_rdata      fetched instruction word
//   icache_ren        read request
//   icache_addr       request address, stable while icache_stall=1
//   if_id_valid/pc/inst  IF/ID pipeline register
//   fetch_busy        the request in flight was held by the cache last cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_pc,
   input  logic        flush_if_id,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        icache_stall,
   input  logic [31:0] icache_rdata,
   output logic        icache_ren,
   output logic [31:0] icache_addr,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_inst,
   output logic        fetch_busy
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] pc;
   logic [31:0] pend_pc;
   logic        buf_valid;
   logic [31:0] buf_pc;
   logic [31:0] buf_inst;
   logic        busy_q;

   logic        fetch_done;
   logic        hold_redirect;

   assign fetch_done    = (state == FETCH) && icache_ren && !icache_stall;
   // A redirect landing on a request the cache is still holding cannot move
   // the address; park the target until the stalled access retires.
   assign hold_redirect = redirect_valid && icache_ren && icache_stall;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = FETCH;
         FETCH:   if (hold_redirect) state_nxt = DROP;
         DROP:    if (!icache_stall) state_nxt = FETCH;
         default: state_nxt = BOOT;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      icache_ren  = 1'b0;
      icache_addr = pc;
      fetch_busy  = busy_q;
      case (state)
         FETCH:   icache_ren = !buf_valid;
         DROP:    icache_ren = 1'b1;
         default: icache_ren = 1'b0;
      endcase
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         pend_pc     <= RESET_PC;
         buf_valid   <= 1'b0;
         buf_pc      <= '0;
         buf_inst    <= NOP_INST;
         busy_q      <= 1'b0;
         if_id_valid <= 1'b0;
         if_id_pc    <= '0;
         if_id_inst  <= NOP_INST;
      end else begin
         busy_q <= icache_ren && icache_stall;

         // PC: redirect wins; a flushed completion still advances the PC.
         if (redirect_valid) begin
            if (hold_redirect) begin
               pend_pc <= redirect_pc;
            end else begin
               pc <= redirect_pc;
            end
         end else if ((state == DROP) && !icache_stall) begin
            pc <= pend_pc;
         end else if (fetch_done) begin
            pc <= pc + 32'd4;
         end

         // Skid buffer
         if (redirect_valid || flush_if_id) begin
            buf_valid <= 1'b0;
         end else if (stall_pc) begin
            if (fetch_done) begin
               buf_valid <= 1'b1;
               buf_pc    <= pc;
               buf_inst  <= icache_rdata;
            end
         end else if (buf_valid) begin
            buf_valid <= 1'b0;
         end

         // IF/ID register
         if (redirect_valid || flush_if_id) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
         end else if (stall_pc) begin
            // hold
         end else if (buf_valid) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= buf_pc;
            if_id_inst  <= buf_inst;
         end else if (fetch_done) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= pc;
            if_id_inst  <= icache_rdata;
         end else begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall_pc;
   logic        flush_if_id;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        icache_stall;
   logic [31:0] icache_rdata;
   logic        icache_ren;
   logic [31:0] icache_addr;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
   logic        fetch_busy;

   int unsigned n_pass;
   int unsigned n_total;

   fetch_unit #(
      .RESET_PC(32'h0000_0000),
      .NOP_INST(NOP)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_pc       (stall_pc),
      .flush_if_id    (flush_if_id),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .icache_stall   (icache_stall),
      .icache_rdata   (icache_rdata),
      .icache_ren     (icache_ren),
      .icache_addr    (icache_addr),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_inst     (if_id_inst),
      .fetch_busy     (fetch_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents as a pure function of address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A00_0003;
   endfunction

   // ------------------------------------------------------- behavioural model
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic [31:0] m_pc;        // address presented to the cache
   bit          m_boot;      // first cycle after reset, no request
   bit          m_drop;      // waiting for a redirected-away access to retire
   logic [31:0] m_tgt;       // where to go once that access retires
   entry_t      m_skid[$];   // instruction parked while decode is stalled
   bit          m_busy;
   bit          m_vld;
   logic [31:0] m_ipc;
   logic [31:0] m_inst;

   function automatic bit m_ren();
      return !m_boot && (m_drop || m_skid.size() == 0);
   endfunction

   task automatic model_step(input logic r, input logic sp, input logic fl,
                             input logic rv, input logic [31:0] rpc, input logic ics);
      bit     ren;
      bit     got;
      entry_t e;
      if (!r) begin
         m_pc = 32'h0; m_boot = 1; m_drop = 0; m_tgt = 32'h0;
         m_skid.delete(); m_busy = 0;
         m_vld = 0; m_ipc = 32'h0; m_inst = NOP;
         return;
      end
      ren    = m_ren();
      got    = ren && !m_drop && !ics;
      m_busy = ren && ics;
      e.pc   = m_pc;
      e.inst = mem_word(m_pc);
      if (rv) begin
         m_skid.delete();
         m_vld  = 0;
         m_inst = NOP;
         if (ren && ics) begin
            m_drop = 1;
            m_tgt  = rpc;
         end else begin
            m_drop = 0;
            m_pc   = rpc;
         end
         m_boot = 0;
      end else begin
         m_boot = 0;
         if (m_drop && !ics) begin
            m_drop = 0;
            m_pc   = m_tgt;
         end
         if (got) m_pc = m_pc + 32'd4;
         if (fl) begin
            m_skid.delete();
            m_vld  = 0;
            m_inst = NOP;
         end else if (sp) begin
            if (got) m_skid.push_back(e);
         end else if (m_skid.size() != 0) begin
            entry_t b;
            b      = m_skid.pop_front();
            m_vld  = 1;
            m_ipc  = b.pc;
            m_inst = b.inst;
         end else if (got) begin
            m_vld  = 1;
            m_ipc  = e.pc;
            m_inst = e.inst;
         end else begin
            m_vld  = 0;
            m_inst = NOP;
         end
      end
   endtask

   // --------------------------------------------------------------- checking
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic compare_model();
      check("ren",   {31'b0, icache_ren},  {31'b0, m_ren()});
      check("addr",  icache_addr,          m_pc);
      check("busy",  {31'b0, fetch_busy},  {31'b0, m_busy});
      check("valid", {31'b0, if_id_valid}, {31'b0, m_vld});
      check("if_pc", if_id_pc,             m_ipc);
      check("inst",  if_id_inst,           m_inst);
   endtask

   // Drive one cycle of inputs (called just after a falling edge), advance
   // the model, then compare at the next falling edge.
   task automatic do_cycle(input logic r, input logic sp, input logic fl,
                           input logic rv, input logic [31:0] rpc, input logic ics);
      rst_n          = r;
      stall_pc       = sp;
      flush_if_id    = fl;
      redirect_valid = rv;
      redirect_pc    = rpc;
      icache_stall   = ics;
      icache_rdata   = ics ? $urandom() : mem_word(icache_addr);
      model_step(r, sp, fl, rv, rpc, ics);
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   initial begin
      logic        sp, fl, rv, ics, r;
      logic [31:0] rpc;
      n_pass = 0;
      n_total = 0;
      rst_n = 0; stall_pc = 0; flush_if_id = 0; redirect_valid = 0;
      redirect_pc = '0; icache_stall = 0; icache_rdata = '0;
      @(negedge clk);
      do_cycle(0, 0, 0, 0, 32'h0, 0);
      do_cycle(0, 0, 0, 0, 32'h0, 0);

      // reset state
      check("rst_ren",   {31'b0, icache_ren},  32'd0);
      check("rst_addr",  icache_addr,          32'h0);
      check("rst_busy",  {31'b0, fetch_busy},  32'd0);
      check("rst_valid", {31'b0, if_id_valid}, 32'd0);
      check("rst_pc",    if_id_pc,             32'h0);
      check("rst_inst",  if_id_inst,           NOP);

      // boot, then zero-wait stream
      do_cycle(1, 0, 0, 0, 32'h0, 0);
      check("c1_ren",  {31'b0, icache_ren}, 32'd1);
      check("c1_addr", icache_addr, 32'h0);
      do_cycle(1, 0, 0, 0, 32'h0, 0);
      check("c2_valid", {31'b0, if_id_valid}, 32'd1);
      check("c2_inst",  if_id_inst, 32'h5A00_0003);
      check("c2_addr",  icache_addr, 32'h4);
      do_cycle(1, 0, 0, 0, 32'h0, 0);
      check("c3_addr", icache_addr, 32'h8);

      // three cache wait states on 0x8
      do_cycle(1, 0, 0, 0, 32'h0, 1);
      check("ws_addr", icache_addr, 32'h8);
      check("ws_busy", {31'b0, fetch_busy}, 32'd1);
      do_cycle(1, 0, 0, 0, 32'h0, 1);
      do_cycle(1, 0, 0, 0, 32'h0, 1);
      check("ws_bubble", {31'b0, if_id_valid}, 32'd0);
      do_cycle(1, 0, 0, 0, 32'h0, 0);
      check("ws_pc",   if_id_pc, 32'h8);
      check("ws_inst", if_id_inst, 32'h5A00_000B);

      // redirect to 0x100 while 0xC is stalled
      do_cycle(1, 0, 0, 0, 32'h0, 1);
      do_cycle(1, 0, 0, 1, 32'h100, 1);
      check("drop_addr", icache_addr, 32'hC);
      check("drop_ren",  {31'b0, icache_ren}, 32'd1);
      do_cycle(1, 0, 0, 0, 32'h0, 1);
      do_cycle(1, 0, 0, 0, 32'h0, 0);
      check("drop_next", icache_addr, 32'h100);
      check("drop_nopc", if_id_pc, 32'h8);
      do_cycle(1, 0, 0, 0, 32'h0, 0);
      check("tgt_pc", if_id_pc, 32'h100);

      // decode stall while 0x104 completes
      do_cycle(1, 1, 0, 0, 32'h0, 0);
      check("skid_ren",  {31'b0, icache_ren}, 32'd0);
      check("skid_hold", if_id_pc, 32'h100);
      do_cycle(1, 1, 0, 0, 32'h0, 0);
      do_cycle(1, 0, 0, 0, 32'h0, 0);
      check("skid_out",  if_id_pc, 32'h104);
      check("skid_next", icache_addr, 32'h108);

      // flush with a buffered instruction
      do_cycle(1, 1, 0, 0, 32'h0, 0);
      do_cycle(1, 0, 1, 0, 32'h0, 0);
      check("fl_inst", if_id_inst, NOP);
      check("fl_addr", icache_addr, 32'h10C);

      // wrap at the top of the address space
      do_cycle(1, 0, 0, 1, 32'hFFFF_FFFC, 0);
      check("wrap_a", icache_addr, 32'hFFFF_FFFC);
      do_cycle(1, 0, 0, 0, 32'h0, 0);
      check("wrap_b",  icache_addr, 32'h0);
      check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         r   = ($urandom_range(0, 99) != 0);
         sp  = ($urandom_range(0, 99) < 20);
         fl  = ($urandom_range(0, 99) < 5);
         rv  = ($urandom_range(0, 99) < 8);
         ics = ($urandom_range(0, 99) < 30);
         case ($urandom_range(0, 3))
            0:       rpc = $urandom();
            1:       rpc = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
            default: rpc = $urandom() & 32'h0000_FFFC;
         endcase
         do_cycle(r, sp, fl, rv, rpc, ics);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
